// File: rtl/divider_block_57_if.sv
// Handshake bundle for the constant divider: dividend in, quotient/remainder out.
interface divider_block_57_if #(
    parameter int WIDTH = 32,
    parameter int REM_W = 16
);
    logic [WIDTH-1:0] i_data0;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_quot;
    logic [REM_W-1:0] o_rem;
    logic             o_exact;
    logic             o_valid;
    logic             i_ready;
    logic             o_busy;

    modport slave (
        input  i_data0, i_valid, i_ready,
        output o_ready, o_quot, o_rem, o_exact, o_valid, o_busy
    );

    modport master (
        output i_data0, i_valid, i_ready,
        input  o_ready, o_quot, o_rem, o_exact, o_valid, o_busy
    );
endinterface

// File: rtl/divider_block_57.sv
// Sequential restoring divider by a fixed constant; data-independent latency of
// WIDTH/BITS_PER_CYCLE cycles, result held in DONE until the consumer takes it.
module divider_block_57 #(
    parameter int WIDTH          = 32,
    parameter int DIVISOR        = 16479,
    parameter int BITS_PER_CYCLE = 1,
    parameter int REM_W          = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    divider_block_57_if.slave bus
);
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [REM_W-1:0] DIV_R = REM_W'(DIVISOR);

    generate
        if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
            $error("divider_block_57: BITS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_dvd;
    logic [REM_W-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quot;
    logic [REM_W-1:0] r_rem_out;
    logic             r_exact;
    logic             r_valid;
    logic             r_ready;
    logic             r_busy;

    logic [WIDTH-1:0] w_dvd;
    logic [REM_W-1:0] w_rem;
    logic [REM_W-1:0] w_trial;

    // Restoring steps for one cycle; quotient bits refill the dividend LSBs.
    always_comb begin
        w_dvd   = r_dvd;
        w_rem   = r_rem;
        w_trial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            // r stays below DIVISOR, so the shifted trial value fits in REM_W bits
            w_trial = {w_rem[REM_W-2:0], w_dvd[WIDTH-1]};
            w_dvd   = {w_dvd[WIDTH-2:0], 1'b0};
            if (w_trial >= DIV_R) begin
                w_rem    = w_trial - DIV_R;
                w_dvd[0] = 1'b1;
            end else begin
                w_rem    = w_trial;
            end
        end
    end

    // Control FSM with working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dvd     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_rem_out <= '0;
            r_exact   <= 1'b0;
            r_valid   <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_valid) begin
                        r_dvd   <= bus.i_data0;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_dvd <= w_dvd;
                    r_rem <= w_rem;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_quot    <= w_dvd;
                        r_rem_out <= w_rem;
                        r_exact   <= (w_rem == '0);
                        r_valid   <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready = r_ready;
    assign bus.o_busy  = r_busy;
    assign bus.o_valid = r_valid;
    assign bus.o_quot  = r_quot;
    assign bus.o_rem   = r_rem_out;
    assign bus.o_exact = r_exact;
endmodule
